alu_issue_seq: RTL and testbench
================================

# alu_issue_seq

Sequential issue/capture front-end for the 32-bit combinational ALU. It accepts an operation request over a valid/ready handshake and decodes the MIPS ALUOp/funct pair into the ALU's 3-bit control code. It drives the ALU operands, waits a programmable settle interval, then captures the sum and computes Z/N/V flags locally. The result is returned over a second valid/ready handshake. It sits between the multicycle datapath controller and the ALU instance, and is the producer/consumer end of the ALU's control and result interface.

## Interface
- SETTLE_CYCLES, default 1: cycles operands and control are held before the result is captured; legal range 1..15.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_aluop  in  2  00 = add (lw/sw), 01 = sub (beq), 10 = R-type (use funct), 11 = reserved
- req_funct  in  6  R-type funct field
- req_a, req_b  in  32 each  operands
- alu_a, alu_b  out  32 each  operands to ALU
- alu_gin  out  3  ALU control code
- alu_sum  in  32  ALU result
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  32  captured result
- rsp_z, rsp_n, rsp_v  out  1 each  zero, negative and overflow flags
- rsp_illegal  out  1  request was undecodable
- rsp_trap  out  1  overflow trap (see Configuration)

## Operation
- FSM states are IDLE, ISSUE and RESP. req_ready = (state == IDLE).
- IDLE: on req_valid, the block accepts the request and registers req_a into alu_a, req_b into alu_b, and the decoded code into alu_gin.
- Decode rules:
  - aluop 00 -> 010; aluop 01 -> 110.
  - aluop 10 with funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct, or aluop 11, is illegal.
- Legal request: IDLE -> ISSUE, and a settle counter loads SETTLE_CYCLES-1.
- Illegal request: IDLE -> RESP directly. rsp_illegal=1, rsp_result=0, all flags 0. alu_* keep their previous values.
- ISSUE: the counter decrements each cycle. On the edge where the counter is 0, the block captures the result and moves to RESP.
- Capture rules:
  - rsp_result = alu_sum.
  - rsp_z = (alu_sum == 0).
  - rsp_n = alu_sum[31] for codes 010/110/000/001, and alu_sum[0] for 111.
  - Add (010): rsp_v = (a[31]==b[31]) && (sum[31]!=a[31]).
  - Sub (110): rsp_v = (a[31]!=b[31]) && (sum[31]!=a[31]).
  - All other codes: rsp_v = 0.
  - The ALU's own flag outputs are not used.
- RESP: rsp_valid=1, and all rsp_* are held stable until rsp_ready=1. On rsp_valid && rsp_ready the FSM returns to IDLE.
- alu_a, alu_b and alu_gin hold their last issued values outside ISSUE.

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_result 0, rsp_z/n/v/illegal/trap 0, alu_a/alu_b 0, alu_gin 010.
- Legal request accepted at edge k: rsp_valid is high after edge k+SETTLE_CYCLES. With the default, rsp_valid is high one cycle after acceptance.
- Illegal request accepted at edge k: rsp_valid is high after edge k.
- Response accepted at edge m: req_ready is high after edge m. Throughput is one request per SETTLE_CYCLES+2 cycles at best. There is no same-cycle turnaround.
- req_valid while not IDLE is ignored; the requester must hold it.
- rsp_ready low for any duration: the FSM stays in RESP and outputs do not change.
- rst_n low at any time, including mid-ISSUE or in RESP: all state and outputs go to reset values immediately. The in-flight request is discarded with no response.
- rst_n deassertion is synchronised externally; the first acceptance can occur on the first edge after release.

## Configuration
- ALU_OVF_TRAP_EN defined:
  - A legal add/sub capture with overflow sets rsp_trap=1 and forces rsp_result=0.
  - rsp_v is still 1, and rsp_z is computed on the forced 0, so rsp_z=1.
- ALU_OVF_TRAP_EN undefined: rsp_trap is tied 0 and rsp_result always equals alu_sum.

## Test plan
- aluop 10, funct 100000, a=0x00000005, b=0x00000003, SETTLE_CYCLES=1 -> alu_gin=010. rsp_valid one cycle after acceptance with result 0x00000008 (ALU model returns a+b), z=0, n=0, v=0.
- aluop 01, a=b=0x12345678 -> alu_gin=110, result 0, z=1, n=0, v=0.
- aluop 00, a=0x7FFFFFFF, b=0x00000001 -> result 0x80000000, n=1, v=1. With ALU_OVF_TRAP_EN: trap=1, result 0, z=1.
- aluop 10, funct 101010, a=0xFFFFFFFF, b=0x00000001, with the ALU returning 1 -> result 1, n=1, v=0. Then funct 000111 -> rsp_valid after the acceptance edge with illegal=1, result 0, alu_gin unchanged.
- SETTLE_CYCLES=4, rsp_ready held low for 10 cycles -> rsp_valid after edge k+4. Outputs stay stable while rsp_ready is low, and req_ready=0 throughout.
- rst_n pulsed low during ISSUE -> all outputs go to reset values, no rsp_valid is produced, and the next request completes normally.

Source files
------------

// File: rtl/alu_issue_seq_if.sv
// Request/response channels between the datapath controller and alu_issue_seq.
// A transfer occurs on any rising edge where valid && ready; the producer holds valid and payload stable until then.
interface alu_issue_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_aluop;
  logic [5:0]  req_funct;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_z;
  logic        rsp_n;
  logic        rsp_v;
  logic        rsp_illegal;
  logic        rsp_trap;

  modport master (
    output req_valid, req_aluop, req_funct, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_z, rsp_n, rsp_v, rsp_illegal, rsp_trap
  );

  modport slave (
    input  req_valid, req_aluop, req_funct, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_z, rsp_n, rsp_v, rsp_illegal, rsp_trap
  );
endinterface

// File: rtl/alu_issue_seq.sv
// Issue/capture front-end for the 32-bit ALU: decodes ALUOp/funct, holds operands for SETTLE_CYCLES, captures sum and flags.
// Optional macro ALU_OVF_TRAP_EN: add/sub overflow raises rsp_trap and forces the result to zero.
module alu_issue_seq #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_issue_seq_if.slave       bus,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [2:0]           alu_gin,
  input  logic [31:0]          alu_sum,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [2:0] GIN_AND = 3'b000;
  localparam logic [2:0] GIN_OR  = 3'b001;
  localparam logic [2:0] GIN_ADD = 3'b010;
  localparam logic [2:0] GIN_SUB = 3'b110;
  localparam logic [2:0] GIN_SLT = 3'b111;
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        accept, capture;

  logic [2:0]  dec_code;
  logic        dec_illegal;

  logic [31:0] cap_result;
  logic        cap_z, cap_n, cap_v, cap_trap;

  logic [31:0] rsp_result_q;
  logic        rsp_z_q, rsp_n_q, rsp_v_q, rsp_illegal_q, rsp_trap_q;

  always_comb begin
    dec_code    = GIN_ADD;
    dec_illegal = 1'b0;
    case (bus.req_aluop)
      2'b00: dec_code = GIN_ADD;
      2'b01: dec_code = GIN_SUB;
      2'b10: begin
        case (bus.req_funct)
          6'b100000: dec_code = GIN_ADD;
          6'b100010: dec_code = GIN_SUB;
          6'b100100: dec_code = GIN_AND;
          6'b100101: dec_code = GIN_OR;
          6'b101010: dec_code = GIN_SLT;
          default:   dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Flags are derived from the held operands and alu_sum; the ALU's own flag outputs are not trusted.
  always_comb begin
    cap_n = (alu_gin == GIN_SLT) ? alu_sum[0] : alu_sum[31];
    cap_v = 1'b0;
    case (alu_gin)
      GIN_ADD: cap_v = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
      GIN_SUB: cap_v = (alu_a[31] != alu_b[31]) && (alu_sum[31] != alu_a[31]);
      default: cap_v = 1'b0;
    endcase
`ifdef ALU_OVF_TRAP_EN
    cap_trap   = cap_v;
    cap_result = cap_v ? 32'd0 : alu_sum;
`else
    cap_trap   = 1'b0;
    cap_result = alu_sum;
`endif
    cap_z = (cap_result == 32'd0);
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = dec_illegal ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= 4'd0;
      alu_a         <= 32'd0;
      alu_b         <= 32'd0;
      alu_gin       <= GIN_ADD;
      rsp_result_q  <= 32'd0;
      rsp_z_q       <= 1'b0;
      rsp_n_q       <= 1'b0;
      rsp_v_q       <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_trap_q    <= 1'b0;
    end else begin
      if (accept && !dec_illegal) begin
        alu_a   <= bus.req_a;
        alu_b   <= bus.req_b;
        alu_gin <= dec_code;
        cnt     <= CNT_LOAD;
      end else if (state == ISSUE && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Illegal requests skip the ALU entirely and answer with a zeroed response.
      if (accept && dec_illegal) begin
        rsp_result_q  <= 32'd0;
        rsp_z_q       <= 1'b0;
        rsp_n_q       <= 1'b0;
        rsp_v_q       <= 1'b0;
        rsp_illegal_q <= 1'b1;
        rsp_trap_q    <= 1'b0;
      end else if (capture) begin
        rsp_result_q  <= cap_result;
        rsp_z_q       <= cap_z;
        rsp_n_q       <= cap_n;
        rsp_v_q       <= cap_v;
        rsp_illegal_q <= 1'b0;
        rsp_trap_q    <= cap_trap;
      end
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_z       = rsp_z_q;
  assign bus.rsp_n       = rsp_n_q;
  assign bus.rsp_v       = rsp_v_q;
  assign bus.rsp_illegal = rsp_illegal_q;
  assign bus.rsp_trap    = rsp_trap_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq: one instance with SETTLE_CYCLES=1, one with SETTLE_CYCLES=4, each fed by a behavioural ALU.
module tb_alu_issue_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_seq_if if1 ();
  alu_issue_seq_if if4 ();

  logic [31:0] a1, b1, sum1, a4, b4, sum4;
  logic [2:0]  gin1, gin4;
  logic [1:0]  st1, st4;

  int vecs = 0;
  int errs = 0;

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] g);
    case (g)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign sum1 = alu_model(a1, b1, gin1);
  assign sum4 = alu_model(a4, b4, gin4);

  alu_issue_seq #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave),
    .alu_a(a1), .alu_b(b1), .alu_gin(gin1), .alu_sum(sum1), .state_dbg(st1)
  );

  alu_issue_seq #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave),
    .alu_a(a4), .alu_b(b4), .alu_gin(gin4), .alu_sum(sum4), .state_dbg(st4)
  );

  // Driver tasks: present a request for one edge; return 1ns after the acceptance edge.
  task automatic send1(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if1.req_valid = 1'b1; if1.req_aluop = op; if1.req_funct = fn; if1.req_a = a; if1.req_b = b;
    @(posedge clk); #1;
    if1.req_valid = 1'b0;
  endtask

  task automatic send4(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if4.req_valid = 1'b1; if4.req_aluop = op; if4.req_funct = fn; if4.req_a = a; if4.req_b = b;
    @(posedge clk); #1;
    if4.req_valid = 1'b0;
  endtask

  task automatic drain1();
    @(negedge clk); if1.rsp_ready = 1'b1;
    @(posedge clk); #1; if1.rsp_ready = 1'b0;
  endtask

  task automatic drain4();
    @(negedge clk); if4.rsp_ready = 1'b1;
    @(posedge clk); #1; if4.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vecs++; if (if1.req_ready !== 1'b1) begin errs++; $display("FAIL reset_req_ready: got %b want 1", if1.req_ready); end
    vecs++; if (if1.rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid: got %b want 0", if1.rsp_valid); end
    vecs++; if (if1.rsp_result !== 32'd0) begin errs++; $display("FAIL reset_result: got %h want 0", if1.rsp_result); end
    vecs++; if ({if1.rsp_z, if1.rsp_n, if1.rsp_v, if1.rsp_illegal, if1.rsp_trap} !== 5'b0) begin errs++; $display("FAIL reset_flags: got %b want 00000", {if1.rsp_z, if1.rsp_n, if1.rsp_v, if1.rsp_illegal, if1.rsp_trap}); end
    vecs++; if (a1 !== 32'd0 || b1 !== 32'd0) begin errs++; $display("FAIL reset_operands: got %h/%h want 0/0", a1, b1); end
    vecs++; if (gin1 !== 3'b010) begin errs++; $display("FAIL reset_gin: got %b want 010", gin1); end
    vecs++; if (st1 !== 2'd0) begin errs++; $display("FAIL reset_state: got %0d want 0", st1); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add();
    send1(2'b10, 6'b100000, 32'h5, 32'h3);
    vecs++; if (gin1 !== 3'b010) begin errs++; $display("FAIL add_gin: got %b want 010", gin1); end
    vecs++; if (a1 !== 32'h5 || b1 !== 32'h3) begin errs++; $display("FAIL add_operands: got %h/%h want 5/3", a1, b1); end
    vecs++; if (if1.rsp_valid !== 1'b0 || if1.req_ready !== 1'b0) begin errs++; $display("FAIL add_issue_hs: got valid=%b ready=%b want 0/0", if1.rsp_valid, if1.req_ready); end
    @(posedge clk); #1;
    vecs++; if (if1.rsp_valid !== 1'b1) begin errs++; $display("FAIL add_latency: got rsp_valid=%b want 1", if1.rsp_valid); end
    vecs++; if (if1.rsp_result !== 32'h8) begin errs++; $display("FAIL add_result: got %h want 00000008", if1.rsp_result); end
    vecs++; if ({if1.rsp_z, if1.rsp_n, if1.rsp_v, if1.rsp_illegal, if1.rsp_trap} !== 5'b0) begin errs++; $display("FAIL add_flags: got %b want 00000", {if1.rsp_z, if1.rsp_n, if1.rsp_v, if1.rsp_illegal, if1.rsp_trap}); end
    drain1();
    vecs++; if (if1.req_ready !== 1'b1 || if1.rsp_valid !== 1'b0) begin errs++; $display("FAIL add_drain: got ready=%b valid=%b want 1/0", if1.req_ready, if1.rsp_valid); end
  endtask

  task automatic test_sub_zero();
    send1(2'b01, 6'b000000, 32'h12345678, 32'h12345678);
    vecs++; if (gin1 !== 3'b110) begin errs++; $display("FAIL sub_gin: got %b want 110", gin1); end
    @(posedge clk); #1;
    vecs++; if (if1.rsp_result !== 32'd0) begin errs++; $display("FAIL sub_result: got %h want 0", if1.rsp_result); end
    vecs++; if ({if1.rsp_z, if1.rsp_n, if1.rsp_v} !== 3'b100) begin errs++; $display("FAIL sub_flags: got znv=%b want 100", {if1.rsp_z, if1.rsp_n, if1.rsp_v}); end
    drain1();
  endtask

  task automatic test_overflow();
    send1(2'b00, 6'b000000, 32'h7FFFFFFF, 32'h00000001);
    @(posedge clk); #1;
    vecs++; if (if1.rsp_v !== 1'b1) begin errs++; $display("FAIL addovf_v: got %b want 1", if1.rsp_v); end
`ifdef ALU_OVF_TRAP_EN
    vecs++; if (if1.rsp_result !== 32'd0) begin errs++; $display("FAIL addovf_result: got %h want 0", if1.rsp_result); end
    vecs++; if (if1.rsp_trap !== 1'b1 || if1.rsp_z !== 1'b1) begin errs++; $display("FAIL addovf_trap: got trap=%b z=%b want 1/1", if1.rsp_trap, if1.rsp_z); end
`else
    vecs++; if (if1.rsp_result !== 32'h80000000) begin errs++; $display("FAIL addovf_result: got %h want 80000000", if1.rsp_result); end
    vecs++; if (if1.rsp_n !== 1'b1 || if1.rsp_z !== 1'b0 || if1.rsp_trap !== 1'b0) begin errs++; $display("FAIL addovf_flags: got n=%b z=%b trap=%b want 1/0/0", if1.rsp_n, if1.rsp_z, if1.rsp_trap); end
`endif
    drain1();
    // Negative minus positive crossing into positive range: subtract overflow.
    send1(2'b10, 6'b100010, 32'h80000000, 32'h00000001);
    @(posedge clk); #1;
    vecs++; if (if1.rsp_v !== 1'b1) begin errs++; $display("FAIL subovf_v: got %b want 1", if1.rsp_v); end
`ifdef ALU_OVF_TRAP_EN
    vecs++; if (if1.rsp_result !== 32'd0 || if1.rsp_trap !== 1'b1 || if1.rsp_z !== 1'b1) begin errs++; $display("FAIL subovf_trap: got %h trap=%b z=%b want 0/1/1", if1.rsp_result, if1.rsp_trap, if1.rsp_z); end
`else
    vecs++; if (if1.rsp_result !== 32'h7FFFFFFF || if1.rsp_n !== 1'b0 || if1.rsp_trap !== 1'b0) begin errs++; $display("FAIL subovf_result: got %h n=%b trap=%b want 7fffffff/0/0", if1.rsp_result, if1.rsp_n, if1.rsp_trap); end
`endif
    drain1();
  endtask

  task automatic test_logic_ops();
    send1(2'b10, 6'b100100, 32'hF0F0FF00, 32'h0FF0F0F0);
    vecs++; if (gin1 !== 3'b000) begin errs++; $display("FAIL and_gin: got %b want 000", gin1); end
    @(posedge clk); #1;
    vecs++; if (if1.rsp_result !== 32'h00F0F000 || if1.rsp_n !== 1'b0 || if1.rsp_v !== 1'b0) begin errs++; $display("FAIL and_result: got %h n=%b v=%b want 00f0f000/0/0", if1.rsp_result, if1.rsp_n, if1.rsp_v); end
    drain1();
    send1(2'b10, 6'b100101, 32'hF0F0FF00, 32'h0FF0F0F0);
    vecs++; if (gin1 !== 3'b001) begin errs++; $display("FAIL or_gin: got %b want 001", gin1); end
    @(posedge clk); #1;
    vecs++; if (if1.rsp_result !== 32'hFFF0FFF0 || if1.rsp_n !== 1'b1 || if1.rsp_v !== 1'b0) begin errs++; $display("FAIL or_result: got %h n=%b v=%b want fff0fff0/1/0", if1.rsp_result, if1.rsp_n, if1.rsp_v); end
    drain1();
  endtask

  task automatic test_slt_illegal();
    send1(2'b10, 6'b101010, 32'hFFFFFFFF, 32'h00000001);
    vecs++; if (gin1 !== 3'b111) begin errs++; $display("FAIL slt_gin: got %b want 111", gin1); end
    @(posedge clk); #1;
    vecs++; if (if1.rsp_result !== 32'd1) begin errs++; $display("FAIL slt_result: got %h want 00000001", if1.rsp_result); end
    vecs++; if ({if1.rsp_z, if1.rsp_n, if1.rsp_v, if1.rsp_trap} !== 4'b0100) begin errs++; $display("FAIL slt_flags: got znvt=%b want 0100", {if1.rsp_z, if1.rsp_n, if1.rsp_v, if1.rsp_trap}); end
    drain1();
    send1(2'b10, 6'b000111, 32'hAAAAAAAA, 32'h55555555);
    vecs++; if (if1.rsp_valid !== 1'b1 || if1.rsp_illegal !== 1'b1) begin errs++; $display("FAIL illegal_resp: got valid=%b illegal=%b want 1/1", if1.rsp_valid, if1.rsp_illegal); end
    vecs++; if (if1.rsp_result !== 32'd0 || {if1.rsp_z, if1.rsp_n, if1.rsp_v, if1.rsp_trap} !== 4'b0) begin errs++; $display("FAIL illegal_zero: got %h flags=%b want 0/0000", if1.rsp_result, {if1.rsp_z, if1.rsp_n, if1.rsp_v, if1.rsp_trap}); end
    vecs++; if (gin1 !== 3'b111 || a1 !== 32'hFFFFFFFF) begin errs++; $display("FAIL illegal_hold: got gin=%b a=%h want 111/ffffffff", gin1, a1); end
    drain1();
    send1(2'b11, 6'b100000, 32'h1, 32'h1);
    vecs++; if (if1.rsp_valid !== 1'b1 || if1.rsp_illegal !== 1'b1 || gin1 !== 3'b111) begin errs++; $display("FAIL aluop11: got valid=%b illegal=%b gin=%b want 1/1/111", if1.rsp_valid, if1.rsp_illegal, gin1); end
    drain1();
  endtask

  task automatic test_back_to_back();
    send1(2'b00, 6'b000000, 32'd10, 32'd20);
    // Second request held while the first sits in ISSUE/RESP: it must be ignored until IDLE.
    @(negedge clk);
    if1.req_valid = 1'b1; if1.req_aluop = 2'b01; if1.req_a = 32'd50; if1.req_b = 32'd8;
    @(posedge clk); #1;
    vecs++; if (if1.rsp_result !== 32'd30 || a1 !== 32'd10) begin errs++; $display("FAIL b2b_first: got %0d a=%0d want 30/10", if1.rsp_result, a1); end
    if1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    if1.rsp_ready = 1'b0;
    vecs++; if (if1.req_ready !== 1'b1 || a1 !== 32'd10) begin errs++; $display("FAIL b2b_turnaround: got ready=%b a=%0d want 1/10", if1.req_ready, a1); end
    @(posedge clk); #1;
    if1.req_valid = 1'b0;
    vecs++; if (a1 !== 32'd50 || gin1 !== 3'b110) begin errs++; $display("FAIL b2b_second_issue: got a=%0d gin=%b want 50/110", a1, gin1); end
    @(posedge clk); #1;
    vecs++; if (if1.rsp_valid !== 1'b1 || if1.rsp_result !== 32'd42) begin errs++; $display("FAIL b2b_second_result: got valid=%b %0d want 1/42", if1.rsp_valid, if1.rsp_result); end
    drain1();
  endtask

  task automatic test_settle_stall();
    send4(2'b00, 6'b000000, 32'd100, 32'd23);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      vecs++; if (if4.rsp_valid !== 1'b0 || if4.req_ready !== 1'b0) begin errs++; $display("FAIL settle_wait%0d: got valid=%b ready=%b want 0/0", i, if4.rsp_valid, if4.req_ready); end
    end
    @(posedge clk); #1;
    vecs++; if (if4.rsp_valid !== 1'b1 || if4.rsp_result !== 32'd123) begin errs++; $display("FAIL settle_capture: got valid=%b %0d want 1/123", if4.rsp_valid, if4.rsp_result); end
    if4.req_valid = 1'b1; if4.req_aluop = 2'b01; if4.req_a = 32'd7; if4.req_b = 32'd7;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vecs++; if (if4.rsp_valid !== 1'b1 || if4.req_ready !== 1'b0 || if4.rsp_result !== 32'd123 || {if4.rsp_z, if4.rsp_n, if4.rsp_v} !== 3'b000 || a4 !== 32'd100) begin errs++; $display("FAIL stall_hold%0d: got valid=%b ready=%b %0d znv=%b a=%0d want 1/0/123/000/100", i, if4.rsp_valid, if4.req_ready, if4.rsp_result, {if4.rsp_z, if4.rsp_n, if4.rsp_v}, a4); end
    end
    if4.req_valid = 1'b0;
    drain4();
    vecs++; if (if4.req_ready !== 1'b1) begin errs++; $display("FAIL stall_release: got ready=%b want 1", if4.req_ready); end
  endtask

  task automatic test_reset_mid_issue();
    bit seen = 1'b0;
    send4(2'b00, 6'b000000, 32'h11111111, 32'h22222222);
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b0; #1;
    vecs++; if (if4.req_ready !== 1'b1 || if4.rsp_valid !== 1'b0 || st4 !== 2'd0) begin errs++; $display("FAIL rst_mid_hs: got ready=%b valid=%b state=%0d want 1/0/0", if4.req_ready, if4.rsp_valid, st4); end
    vecs++; if (a4 !== 32'd0 || b4 !== 32'd0 || gin4 !== 3'b010 || if4.rsp_result !== 32'd0) begin errs++; $display("FAIL rst_mid_regs: got a=%h b=%h gin=%b res=%h want 0/0/010/0", a4, b4, gin4, if4.rsp_result); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (if4.rsp_valid === 1'b1) seen = 1'b1;
    end
    vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL rst_mid_no_rsp: got rsp_valid seen=%b want 0", seen); end
    send4(2'b10, 6'b100010, 32'd9, 32'd4);
    repeat (3) @(posedge clk); #1;
    vecs++; if (if4.rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_after_early: got valid=%b want 0", if4.rsp_valid); end
    @(posedge clk); #1;
    vecs++; if (if4.rsp_valid !== 1'b1 || if4.rsp_result !== 32'd5 || if4.rsp_illegal !== 1'b0) begin errs++; $display("FAIL rst_after_result: got valid=%b %0d illegal=%b want 1/5/0", if4.rsp_valid, if4.rsp_result, if4.rsp_illegal); end
    drain4();
  endtask

  initial begin
    if1.req_valid = 1'b0; if1.req_aluop = 2'b00; if1.req_funct = 6'd0; if1.req_a = 32'd0; if1.req_b = 32'd0; if1.rsp_ready = 1'b0;
    if4.req_valid = 1'b0; if4.req_aluop = 2'b00; if4.req_funct = 6'd0; if4.req_a = 32'd0; if4.req_b = 32'd0; if4.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_sub_zero();
    test_overflow();
    test_logic_ops();
    test_slt_illegal();
    test_back_to_back();
    test_settle_stall();
    test_reset_mid_issue();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
